nibble_spi_rx: RTL and testbench

Receive stage directly downstream of the nibble-serial SPI transmitter: accepts the 4-bit data bus, its strobe clock and frame enable from the transmitter, reassembles nibble pairs into bytes, and buffers them for the decryption/consumer logic through a valid/ready port. All link inputs are asynchronous to `clk` and are synchronised before use.

---
 rtl/nibble_spi_pkg.sv | 21 ++
 rtl/byte_fifo.sv | 75 +++++++
 rtl/nibble_spi_rx.sv | 146 ++++++++++++++
 tb/tb_nibble_spi_rx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_spi_pkg.sv
// Shared types and constants for the nibble-serial SPI receive path.
package nibble_spi_pkg;

    localparam int unsigned NIBBLE_W        = 4;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } rx_state_t;

    // One synchroniser stage: all link inputs travel together to stay aligned.
    typedef struct packed {
        logic                strb;
        logic                en;
        logic [NIBBLE_W-1:0] data;
    } link_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte buffer with registered head output; a push into a full buffer
// without a simultaneous pop is dropped and reported on drop_c.
module byte_fifo
    import nibble_spi_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        pop_ok   = pop && !empty_q;
        push_ok  = push && (!full_q || pop_ok);
        drop_c   = push && full_q && !pop_ok;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
        // Head is registered so it holds its last value once the buffer empties.
        dout_d   = empty_d ? dout_q : mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/nibble_spi_rx.sv
// Receive stage for the nibble-serial SPI link: synchronises the link,
// pairs high/low nibbles into bytes and buffers them for a valid/ready consumer.
module nibble_spi_rx
    import nibble_spi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_clk_in,
    input  logic                spi_en_in,
    input  logic [NIBBLE_W-1:0] spi_data_in,
    output logic [BYTE_W-1:0]   byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                overflow,
    output logic                frame_err,
    output logic                busy
);

    link_t                   link_in;
    link_t [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                    strb_prev_q, strb_prev_d;
    logic                    edge_q, edge_d;
    logic                    en_q, en_d;
    logic [NIBBLE_W-1:0]     nib_q, nib_d;
    logic [NIBBLE_W-1:0]     hi_q, hi_d;
    rx_state_t               state_q, state_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q, busy_d;
    logic                    push_c;
    logic                    pop_c;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop_c;

    // Synchroniser chain plus one aligned stage carrying the strobe edge pulse.
    always_comb begin
        link_in.strb = spi_clk_in;
        link_in.en   = spi_en_in;
        link_in.data = spi_data_in;
        sync_d       = {sync_q[SYNC_STAGES-2:0], link_in};
        strb_prev_d  = sync_q[SYNC_STAGES-1].strb;
        edge_d       = sync_q[SYNC_STAGES-1].strb && !strb_prev_q;
        en_d         = sync_q[SYNC_STAGES-1].en;
        nib_d        = sync_q[SYNC_STAGES-1].data;
    end

    // Frame FSM: an edge counts only while the synchronised enable is high.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        push_c      = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_q) begin
                    if (edge_q) begin
                        hi_d    = nib_q;
                        state_d = LO;
                    end else begin
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (edge_q) begin
                    hi_d    = nib_q;
                    state_d = LO;
                end
            end
            LO: begin
                if (!en_q) begin
                    frame_err_d = 1'b1;
                    hi_d        = '0;
                    state_d     = IDLE;
                end else if (edge_q) begin
                    push_c  = 1'b1;
                    state_d = HI;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        pop_c      = byte_ready && !fifo_empty;
        overflow_d = drop_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            strb_prev_q <= 1'b0;
            edge_q      <= 1'b0;
            en_q        <= 1'b0;
            nib_q       <= '0;
            hi_q        <= '0;
            state_q     <= IDLE;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            strb_prev_q <= strb_prev_d;
            edge_q      <= edge_d;
            en_q        <= en_d;
            nib_q       <= nib_d;
            hi_q        <= hi_d;
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
        end
    end

    byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_c),
        .din    ({hi_q, nib_q}),
        .pop    (pop_c),
        .dout   (byte_out),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .drop_c (drop_c)
    );

    // A full buffer with a coincident pop still accepts; the drop itself is in the buffer.
    logic unused_full;
    assign unused_full = fifo_full;

    assign byte_valid = !fifo_empty;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nibble_spi_rx.sv
// Scoreboard bench for nibble_spi_rx: expected bytes are queued as frames are
// driven and checked as the consumer accepts them.
module tb_nibble_spi_rx;

    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          VALID_LAT   = SYNC_STAGES + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_clk_in;
    logic       spi_en_in;
    logic [3:0] spi_data_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       overflow;
    logic       frame_err;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    int         ovf_cnt = 0;
    int         ferr_cnt = 0;
    int         pops_seen = 0;
    logic       busy_seen = 1'b0;
    logic       sampled_valid = 1'b0;

    always #5 clk = ~clk;

    nibble_spi_rx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk_in  (spi_clk_in),
        .spi_en_in   (spi_en_in),
        .spi_data_in (spi_data_in),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    // One clock: sample on the falling edge, consume/compare, return 1 after the rising edge.
    task automatic cycle();
        logic [7:0] exp_b;
        @(negedge clk);
        sampled_valid = byte_valid;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (overflow === 1'b1) ovf_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
            pops_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got=%02h exp=none", byte_out);
            end else begin
                exp_b = exp_q.pop_front();
                if (byte_out !== exp_b) begin
                    errors++;
                    $display("FAIL pop_data got=%02h exp=%02h", byte_out, exp_b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One strobe period; lat = clocks from strobe rise to byte_valid rising (-1 if none).
    task automatic send_nibble(input logic [3:0] n, input int pop_at, output int lat);
        logic prev_v;
        spi_data_in = n;
        cycle();
        spi_clk_in = 1'b1;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) spi_clk_in = 1'b0;
            if (pop_at >= 0 && i == pop_at) byte_ready = 1'b1;
            if (pop_at >= 0 && i == pop_at + 1) byte_ready = 1'b0;
            prev_v = sampled_valid;
            cycle();
            if (lat < 0 && sampled_valid && !prev_v) lat = i;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int lat;
        send_nibble(b[7:4], -1, lat);
        send_nibble(b[3:0], -1, lat);
    endtask

    task automatic start_frame();
        spi_en_in = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic end_frame();
        spi_en_in = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        checks++;
        if ({byte_out, byte_valid, overflow, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%03h exp=000",
                     {byte_out, byte_valid, overflow, frame_err, busy});
        end
        rst_n = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        byte_ready = 1'b1;
        ferr_cnt   = 0;
        start_frame();
        send_nibble(4'hA, -1, lat);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_frame got=%b exp=1", busy);
        end
        rst_n = 1'b0;
        cycle();
        checks++;
        if ({byte_out, byte_valid, overflow, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%03h exp=000",
                     {byte_out, byte_valid, overflow, frame_err, busy});
        end
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        exp_q.push_back(8'h12);
        send_nibble(4'h1, -1, lat);
        send_nibble(4'h2, -1, lat);
        end_frame();
        drain(40);
        checks++;
        if (ferr_cnt != 0) begin
            errors++;
            $display("FAIL mid_reset_frame_err got=%0d exp=0", ferr_cnt);
        end
    endtask

    task automatic test_single_frame();
        int lat;
        byte_ready = 1'b1;
        ovf_cnt    = 0;
        start_frame();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'(k));
            send_nibble(4'h0, -1, lat);
            send_nibble(4'(k), -1, lat);
            checks++;
            if (lat != VALID_LAT) begin
                errors++;
                $display("FAIL valid_latency byte=%0d got=%0d exp=%0d", k, lat, VALID_LAT);
            end
        end
        end_frame();
        drain(40);
        checks++;
        if (ovf_cnt != 0) begin
            errors++;
            $display("FAIL single_overflow got=%0d exp=0", ovf_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        int         p0;
        byte_ready = 1'b0;
        ovf_cnt    = 0;
        start_frame();
        for (int k = 0; k < 5; k++) begin
            b = 8'h10 + 8'(k);
            if (k < 4) exp_q.push_back(b);
            send_byte(b);
            if (k == 3) begin
                checks++;
                if (ovf_cnt != 0 || byte_valid !== 1'b1 || byte_out !== 8'h10) begin
                    errors++;
                    $display("FAIL bp_full ovf=%0d valid=%b head=%02h exp=0/1/10",
                             ovf_cnt, byte_valid, byte_out);
                end
            end
        end
        checks++;
        if (ovf_cnt != 1) begin
            errors++;
            $display("FAIL bp_overflow_pulses got=%0d exp=1", ovf_cnt);
        end
        end_frame();
        p0 = pops_seen;
        byte_ready = 1'b1;
        drain(20);
        repeat (3) cycle();
        checks++;
        if (pops_seen - p0 != 4 || byte_valid !== 1'b0 || byte_out !== 8'h13) begin
            errors++;
            $display("FAIL bp_drained pops=%0d valid=%b head=%02h exp=4/0/13",
                     pops_seen - p0, byte_valid, byte_out);
        end
    endtask

    task automatic test_full_pop_push();
        int lat;
        int p0;
        byte_ready = 1'b0;
        ovf_cnt    = 0;
        start_frame();
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h20 + 8'(k));
        for (int k = 0; k < 4; k++) send_byte(8'h20 + 8'(k));
        send_nibble(4'h2, -1, lat);
        p0 = pops_seen;
        send_nibble(4'h4, SYNC_STAGES + 1, lat);
        checks++;
        if (pops_seen - p0 != 1 || ovf_cnt != 0) begin
            errors++;
            $display("FAIL fpp_pop pops=%0d ovf=%0d exp=1/0", pops_seen - p0, ovf_cnt);
        end
        checks++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h21) begin
            errors++;
            $display("FAIL fpp_head valid=%b head=%02h exp=1/21", byte_valid, byte_out);
        end
        end_frame();
        p0 = pops_seen;
        byte_ready = 1'b1;
        drain(20);
        repeat (3) cycle();
        checks++;
        if (pops_seen - p0 != 4) begin
            errors++;
            $display("FAIL fpp_count got=%0d exp=4", pops_seen - p0);
        end
    endtask

    task automatic test_odd_frame();
        int lat;
        byte_ready = 1'b1;
        ferr_cnt   = 0;
        start_frame();
        exp_q.push_back(8'h56);
        send_nibble(4'h5, -1, lat);
        send_nibble(4'h6, -1, lat);
        send_nibble(4'h7, -1, lat);
        end_frame();
        checks++;
        if (ferr_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL odd_frame_err pulses=%0d busy=%b exp=1/0", ferr_cnt, busy);
        end
        drain(20);
        start_frame();
        exp_q.push_back(8'h89);
        send_nibble(4'h8, -1, lat);
        send_nibble(4'h9, -1, lat);
        end_frame();
        drain(20);
        checks++;
        if (ferr_cnt != 1) begin
            errors++;
            $display("FAIL odd_next_frame pulses=%0d exp=1", ferr_cnt);
        end
    endtask

    task automatic test_strobe_en_low();
        int lat;
        int p0;
        byte_ready = 1'b1;
        spi_en_in  = 1'b0;
        repeat (2) cycle();
        busy_seen = 1'b0;
        p0 = pops_seen;
        for (int k = 0; k < 3; k++) send_nibble(4'hF, -1, lat);
        repeat (4) cycle();
        checks++;
        if (busy_seen !== 1'b0 || pops_seen != p0 || byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_low_strobe busy_seen=%b pops=%0d valid=%b exp=0/0/0",
                     busy_seen, pops_seen - p0, byte_valid);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        spi_clk_in  = 1'b0;
        spi_en_in   = 1'b0;
        spi_data_in = 4'h0;
        byte_ready  = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_single_frame();
        test_backpressure();
        test_full_pop_push();
        test_odd_frame();
        test_strobe_en_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
